// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx
//
// Receives PS/2 keyboard frames and turns scan-code set 2 make/break
// sequences into a held keycode for the turret/game control FSMs.
// Consumers sample keycode_o every clock: 8'h00 means no key is held.
//
// Ports
//   clk_i          system clock, all logic on its rising edge
//   reset_i        synchronous, active-high reset
//   ps2_clk_i      raw keyboard clock (asynchronous)
//   ps2_data_i     raw keyboard data (asynchronous)
//   keycode_o      code of the most recently pressed, still-held key
//   key_ext_o      keycode_o was prefixed by E0 (extended key)
//   make_strobe_o  1-cycle pulse on every accepted make (typematic repeats too)
//   break_strobe_o 1-cycle pulse when the held key is released
//   frame_err_o    1-cycle pulse on a parity, stop or timeout error
module ps2_keycode_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] keycode_o,
    output logic       key_ext_o,
    output logic       make_strobe_o,
    output logic       break_strobe_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q;
    logic [1:0]    clkSync_q;
    logic [1:0]    dataSync_q;
    logic          clkPrev_q;
    logic [2:0]    bitCnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [CW-1:0] toCnt_q;
    logic [CW-1:0] toCnt_d;
    logic          extPend_q;
    logic          brkPend_q;
    logic [7:0]    keycode_q;
    logic          keyExt_q;
    logic          make_q;
    logic          break_q;
    logic          err_q;

    logic fallEdge;
    logic dataBit;
    logic timeoutHit;
    logic frameOk;

    // Both keyboard lines are asynchronous, so each goes through two flops
    // before anything looks at it. Resetting to 1 matches the idle bus level
    // so leaving reset never fakes a falling edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2_data_i};
            clkPrev_q  <= clkSync_q[1];
        end
    end

    // Edge detect, frame check and the timeout condition. A timeout only
    // fires on a cycle with no falling edge, since an edge restarts the wait.
    always_comb begin
        fallEdge   = clkPrev_q & ~clkSync_q[1];
        dataBit    = dataSync_q[1];
        timeoutHit = (state_q != S_IDLE) && !fallEdge && (toCnt_q == TO_LAST);
        frameOk    = dataBit && (^{shift_q, parity_q});
    end

    // The inactivity counter only runs while a frame is in flight.
    always_comb begin
        toCnt_d = toCnt_q + CW'(1);
        if (state_q == S_IDLE || fallEdge || timeoutHit) begin
            toCnt_d = '0;
        end
    end

    // Receive FSM plus byte decode. Decoding happens on the same edge that
    // leaves STOP, so the outputs move one cycle after the stop-bit edge.
    // A release only clears the keycode if it names exactly the held key,
    // including its E0 flag; a release of any other key is ignored.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            toCnt_q   <= '0;
            extPend_q <= 1'b0;
            brkPend_q <= 1'b0;
            keycode_q <= '0;
            keyExt_q  <= 1'b0;
            make_q    <= 1'b0;
            break_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            toCnt_q <= toCnt_d;
            make_q  <= 1'b0;
            break_q <= 1'b0;
            err_q   <= 1'b0;

            if (timeoutHit) begin
                state_q   <= S_IDLE;
                err_q     <= 1'b1;
                extPend_q <= 1'b0;
                brkPend_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (fallEdge && !dataBit) begin
                            state_q  <= S_DATA;
                            bitCnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        if (fallEdge) begin
                            shift_q  <= {dataBit, shift_q[7:1]};
                            bitCnt_q <= bitCnt_q + 3'd1;
                            if (bitCnt_q == 3'd7) begin
                                state_q <= S_PARITY;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (fallEdge) begin
                            parity_q <= dataBit;
                            state_q  <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (fallEdge) begin
                            state_q <= S_IDLE;
                            if (!frameOk) begin
                                err_q     <= 1'b1;
                                extPend_q <= 1'b0;
                                brkPend_q <= 1'b0;
                            end else if (shift_q == 8'hE0) begin
                                extPend_q <= 1'b1;
                            end else if (shift_q == 8'hF0) begin
                                brkPend_q <= 1'b1;
                            end else begin
                                extPend_q <= 1'b0;
                                brkPend_q <= 1'b0;
                                if (!brkPend_q) begin
                                    keycode_q <= shift_q;
                                    keyExt_q  <= extPend_q;
                                    make_q    <= 1'b1;
                                end else if (shift_q == keycode_q && extPend_q == keyExt_q) begin
                                    keycode_q <= '0;
                                    keyExt_q  <= 1'b0;
                                    break_q   <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign keycode_o      = keycode_q;
    assign key_ext_o      = keyExt_q;
    assign make_strobe_o  = make_q;
    assign break_strobe_o = break_q;
    assign frame_err_o    = err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx
//
// Drives PS/2 frames into ps2_keycode_rx and checks the held keycode and
// strobes against a byte-level model of the make/break protocol.
module tb_ps2_keycode_rx;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 30;

    localparam logic [1:0] EV_MAKE  = 2'd1;
    localparam logic [1:0] EV_BREAK = 2'd2;
    localparam logic [1:0] EV_ERR   = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] key;
        logic       ext;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2Clk = 1'b1;
    logic       ps2Data = 1'b1;
    logic [7:0] keycode;
    logic       keyExt;
    logic       makeStb;
    logic       breakStb;
    logic       frameErr;

    int checks = 0;
    int passes = 0;
    int makeCount = 0;
    int breakCount = 0;
    int errCount = 0;

    // Model state: mKey/mExt is the key the model believes is held once all
    // sent bytes are decoded; curKey/curExt is what the DUT should be showing
    // right now, advanced only when the DUT strobes.
    logic [7:0] mKey = 8'h00;
    logic       mExt = 1'b0;
    logic       extPend = 1'b0;
    logic       brkPend = 1'b0;
    logic [7:0] curKey = 8'h00;
    logic       curExt = 1'b0;
    ev_t        expQ[$];

    ps2_keycode_rx #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .ps2_clk_i      (ps2Clk),
        .ps2_data_i     (ps2Data),
        .keycode_o      (keycode),
        .key_ext_o      (keyExt),
        .make_strobe_o  (makeStb),
        .break_strobe_o (breakStb),
        .frame_err_o    (frameErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] kindVec(input logic [1:0] kind);
        case (kind)
            EV_MAKE:  return 3'b100;
            EV_BREAK: return 3'b010;
            default:  return 3'b001;
        endcase
    endfunction

    // Protocol-level interpretation of one received byte.
    task automatic modelByte(input logic [7:0] b, input logic ok);
        ev_t e;
        if (!ok) begin
            extPend = 1'b0;
            brkPend = 1'b0;
            e = '{kind: EV_ERR, key: mKey, ext: mExt};
            expQ.push_back(e);
        end else if (b == 8'hE0) begin
            extPend = 1'b1;
        end else if (b == 8'hF0) begin
            brkPend = 1'b1;
        end else begin
            if (!brkPend) begin
                mKey = b;
                mExt = extPend;
                e = '{kind: EV_MAKE, key: mKey, ext: mExt};
                expQ.push_back(e);
            end else if (b == mKey && extPend == mExt) begin
                mKey = 8'h00;
                mExt = 1'b0;
                e = '{kind: EV_BREAK, key: 8'h00, ext: 1'b0};
                expQ.push_back(e);
            end
            extPend = 1'b0;
            brkPend = 1'b0;
        end
    endtask

    task automatic modelTimeout();
        modelByte(8'h00, 1'b0);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    // One PS/2 bit: data changes while the clock is high, keyboard then
    // pulls the clock low and releases it.
    task automatic sendBit(input logic b);
        ps2Data = b;
        waitCycles(HALF);
        ps2Clk = 1'b0;
        waitCycles(HALF);
        ps2Clk = 1'b1;
    endtask

    task automatic drainCheck();
        waitCycles(HALF);
        checkOutput("event_drain", 16'(expQ.size()), 16'd0);
        expQ.delete();
        curKey = mKey;
        curExt = mExt;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic parFlip, input logic stopBit);
        logic p;
        p = ~(^b) ^ parFlip;
        modelByte(b, !parFlip && stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            sendBit(b[i]);
        end
        sendBit(p);
        sendBit(stopBit);
        ps2Data = 1'b1;
        drainCheck();
    endtask

    task automatic sendPartial(input logic [7:0] b, input int nBits);
        sendBit(1'b0);
        for (int i = 0; i < nBits; i++) begin
            sendBit(b[i]);
        end
        ps2Data = 1'b1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 reset = 1'b1;
        mKey = 8'h00;
        mExt = 1'b0;
        extPend = 1'b0;
        brkPend = 1'b0;
        curKey = 8'h00;
        curExt = 1'b0;
        expQ.delete();
        waitCycles(3);
        #1 reset = 1'b0;
    endtask

    task automatic clearCounts();
        makeCount = 0;
        breakCount = 0;
        errCount = 0;
    endtask

    // Every cycle out of reset: any strobe must be the next predicted event,
    // and the held key must match what the model says is showing.
    always @(negedge clk) begin
        logic [2:0] s;
        ev_t e;
        if (!reset) begin
            s = {makeStb, breakStb, frameErr};
            if (makeStb)  makeCount++;
            if (breakStb) breakCount++;
            if (frameErr) errCount++;
            if (s != 3'b000) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_strobe", {13'd0, s}, 16'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("strobe_kind", {13'd0, s}, {13'd0, kindVec(e.kind)});
                    curKey = e.key;
                    curExt = e.ext;
                end
            end
            checkOutput("keycode", {8'd0, keycode}, {8'd0, curKey});
            checkOutput("key_ext", {15'd0, keyExt}, {15'd0, curExt});
        end
    end

    initial begin
        waitCycles(4);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_keycode", {8'd0, keycode}, 16'h0000);
        checkOutput("reset_ext", {15'd0, keyExt}, 16'd0);
        checkOutput("reset_strobes", {13'd0, makeStb, breakStb, frameErr}, 16'd0);

        $display("[TB] idle falling edge with data high");
        clearCounts();
        sendBit(1'b1);
        waitCycles(20);
        checkOutput("idle_high_no_err", 16'(errCount), 16'd0);

        $display("[TB] single make 1A");
        clearCounts();
        applyStimulus(8'h1A, 1'b0, 1'b1);
        checkOutput("t1_keycode", {8'd0, keycode}, 16'h001A);
        checkOutput("t1_ext", {15'd0, keyExt}, 16'd0);
        checkOutput("t1_make_pulses", 16'(makeCount), 16'd1);
        checkOutput("t1_err", 16'(errCount), 16'd0);

        $display("[TB] release then press 16");
        clearCounts();
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h1A, 1'b0, 1'b1);
        checkOutput("t2_released", {8'd0, keycode}, 16'h0000);
        checkOutput("t2_break_pulses", 16'(breakCount), 16'd1);
        applyStimulus(8'h16, 1'b0, 1'b1);
        checkOutput("t2_keycode", {8'd0, keycode}, 16'h0016);

        $display("[TB] last key wins, stale release ignored");
        clearCounts();
        applyStimulus(8'h1A, 1'b0, 1'b1);
        applyStimulus(8'h16, 1'b0, 1'b1);
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h1A, 1'b0, 1'b1);
        checkOutput("t3_keycode", {8'd0, keycode}, 16'h0016);
        checkOutput("t3_no_break", 16'(breakCount), 16'd0);

        $display("[TB] bad parity and bad stop");
        clearCounts();
        applyStimulus(8'h1A, 1'b1, 1'b1);
        checkOutput("t4_parity_err", 16'(errCount), 16'd1);
        checkOutput("t4_parity_key", {8'd0, keycode}, 16'h0016);
        clearCounts();
        applyStimulus(8'h1A, 1'b0, 1'b0);
        checkOutput("t4_stop_err", 16'(errCount), 16'd1);
        checkOutput("t4_stop_key", {8'd0, keycode}, 16'h0016);

        $display("[TB] extended key 75");
        clearCounts();
        applyStimulus(8'hE0, 1'b0, 1'b1);
        applyStimulus(8'h75, 1'b0, 1'b1);
        checkOutput("t5_ext_key", {7'd0, keyExt, keycode}, 16'h0175);
        applyStimulus(8'hE0, 1'b0, 1'b1);
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h75, 1'b0, 1'b1);
        checkOutput("t5_ext_release", {7'd0, keyExt, keycode}, 16'h0000);
        applyStimulus(8'hE0, 1'b0, 1'b1);
        applyStimulus(8'h75, 1'b0, 1'b1);
        clearCounts();
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h75, 1'b0, 1'b1);
        checkOutput("t5_plain_release_ignored", {7'd0, keyExt, keycode}, 16'h0175);
        checkOutput("t5_no_break", 16'(breakCount), 16'd0);

        $display("[TB] timeout mid-frame");
        clearCounts();
        modelTimeout();
        sendPartial(8'h1A, 4);
        waitCycles(TIMEOUT + 100);
        checkOutput("t6_timeout_err", 16'(errCount), 16'd1);
        checkOutput("t6_timeout_key", {7'd0, keyExt, keycode}, 16'h0175);
        drainCheck();
        applyStimulus(8'h1A, 1'b0, 1'b1);
        checkOutput("t6_after_timeout", {7'd0, keyExt, keycode}, 16'h001A);

        $display("[TB] reset mid-frame");
        sendPartial(8'h16, 4);
        doReset();
        @(negedge clk);
        checkOutput("t6_reset_key", {7'd0, keyExt, keycode}, 16'h0000);
        checkOutput("t6_reset_strobes", {13'd0, makeStb, breakStb, frameErr}, 16'd0);
        applyStimulus(8'h16, 1'b0, 1'b1);
        checkOutput("t6_after_reset", {7'd0, keyExt, keycode}, 16'h0016);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
